// File: rtl/arilla_bus_pkg.sv
// Shared types and width helpers for the Arilla bus arbiter slice.
package arilla_bus_pkg;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE
   } reqKind_e;

   function automatic int calcBytesPerWord(int dataWidth, int byteSize);
      return dataWidth / byteSize;
   endfunction

   // Byte lanes inside a word are addressed by byte enables, so the word address drops those bits.
   function automatic int calcWordAddressWidth(int byteAddressWidth, int dataWidth, int byteSize);
      int bytesPerWord;
      bytesPerWord = dataWidth / byteSize;
      return (bytesPerWord > 1) ? byteAddressWidth - $clog2(bytesPerWord) : byteAddressWidth;
   endfunction

   function automatic int calcIndexWidth(int count);
      return (count > 1) ? $clog2(count) : 1;
   endfunction

endpackage

// File: rtl/arilla_rr_picker.sv
// Combinational round-robin picker: first requester after `last`, wrapping past the top index.
module arilla_rr_picker
   import arilla_bus_pkg::*;
#(
   parameter int Width = 2,
   localparam int IndexWidth = calcIndexWidth(Width)
) (
   input  logic [Width-1:0]      request,
   input  logic [IndexWidth-1:0] last,
   output logic [Width-1:0]      grant,
   output logic [IndexWidth-1:0] grant_index,
   output logic                  any
);

   // Scan last+1 .. last+Width so `last` itself has the lowest priority.
   always_comb begin
      int   candidate;
      logic found;
      grant       = '0;
      grant_index = '0;
      found       = 1'b0;
      candidate   = 0;
      for (int offset = 1; offset <= Width; offset++) begin
         candidate = (int'(last) + offset) % Width;
         if (request[candidate] && !found) begin
            grant[candidate] = 1'b1;
            grant_index      = IndexWidth'(candidate);
            found            = 1'b1;
         end
      end
      any = found;
   end

endmodule

// File: rtl/arilla_bus_arbiter.sv
// Round-robin arbiter placing ChannelCount Arilla controllers onto one downstream bus,
// with zero-cycle grant, an optional burst limit and per-channel response routing.
module arilla_bus_arbiter
   import arilla_bus_pkg::*;
#(
   parameter int ChannelCount     = 2,
   parameter int DataWidth        = 32,
   parameter int ByteAddressWidth = 32,
   parameter int ByteSize         = 8,
   parameter int MaxBurst         = 4,
   localparam int BytesPerWord     = calcBytesPerWord(DataWidth, ByteSize),
   localparam int WordAddressWidth = calcWordAddressWidth(ByteAddressWidth, DataWidth, ByteSize)
) (
   input  logic                                          clk,
   input  logic                                          rst,
   input  logic [ChannelCount-1:0]                       up_read,
   input  logic [ChannelCount-1:0]                       up_write,
   input  logic [ChannelCount-1:0][WordAddressWidth-1:0] up_address,
   input  logic [ChannelCount-1:0][BytesPerWord-1:0]     up_byte_enable,
   input  logic [ChannelCount-1:0][DataWidth-1:0]        up_data_ctp,
   output logic [ChannelCount-1:0][DataWidth-1:0]        up_data_ptc,
   output logic [ChannelCount-1:0]                       up_hit,
   output logic [ChannelCount-1:0]                       up_inhibit,
   output logic [ChannelCount-1:0]                       up_intercept,
   output logic [ChannelCount-1:0]                       up_stall,
   output logic [ChannelCount-1:0]                       up_grant,
   output logic                                          dn_read,
   output logic                                          dn_write,
   output logic [WordAddressWidth-1:0]                   dn_address,
   output logic [BytesPerWord-1:0]                       dn_byte_enable,
   output logic [DataWidth-1:0]                          dn_data_ctp,
   input  logic [DataWidth-1:0]                          dn_data_ptc,
   input  logic                                          dn_hit,
   input  logic                                          dn_inhibit,
   input  logic                                          dn_intercept
);

   localparam int IndexWidth = calcIndexWidth(ChannelCount);
   localparam int CountWidth = (MaxBurst > 0) ? $clog2(MaxBurst + 1) : 1;
   localparam logic [CountWidth-1:0] BurstLimit = CountWidth'((MaxBurst > 0) ? MaxBurst : 1);
   localparam logic [IndexWidth-1:0] LastReset  = IndexWidth'(ChannelCount - 1);

   logic [IndexWidth-1:0]   owner_q, owner_d;
   logic [IndexWidth-1:0]   last_q, last_d;
   logic                    ownerValid_q, ownerValid_d;
   logic [CountWidth-1:0]   burstCnt_q, burstCnt_d;

   logic [ChannelCount-1:0] request;
   logic [ChannelCount-1:0] ownerOneHot;
   logic [ChannelCount-1:0] pickGrant;
   logic [IndexWidth-1:0]   pickIndex;
   logic                    pickAny;
   logic                    keep;
   logic [ChannelCount-1:0] grant;
   logic [IndexWidth-1:0]   grantIndex;
   logic                    grantValid;

   arilla_rr_picker #(
      .Width(ChannelCount)
   ) picker (
      .request    (request),
      .last       (last_q),
      .grant      (pickGrant),
      .grant_index(pickIndex),
      .any        (pickAny)
   );

   // The owner keeps the bus until its burst budget runs out and somebody else is waiting.
   always_comb begin
      request     = up_read | up_write;
      ownerOneHot = '0;
      for (int i = 0; i < ChannelCount; i++) begin
         if (ownerValid_q && (owner_q == IndexWidth'(i))) begin
            ownerOneHot[i] = 1'b1;
         end
      end
      keep = (|(request & ownerOneHot)) &&
             ((MaxBurst == 0) || (burstCnt_q < BurstLimit) || !(|(request & ~ownerOneHot)));
      if (rst) begin
         grant      = '0;
         grantIndex = '0;
         grantValid = 1'b0;
      end else if (keep) begin
         grant      = ownerOneHot;
         grantIndex = owner_q;
         grantValid = 1'b1;
      end else begin
         grant      = pickGrant;
         grantIndex = pickIndex;
         grantValid = pickAny;
      end
   end

   always_comb begin
      owner_d      = owner_q;
      last_d       = last_q;
      ownerValid_d = 1'b0;
      burstCnt_d   = '0;
      if (grantValid) begin
         owner_d      = grantIndex;
         last_d       = grantIndex;
         ownerValid_d = 1'b1;
         if (keep) begin
            burstCnt_d = (burstCnt_q >= BurstLimit) ? BurstLimit : burstCnt_q + 1'b1;
         end else begin
            burstCnt_d = CountWidth'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         owner_q      <= '0;
         last_q       <= LastReset;
         ownerValid_q <= 1'b0;
         burstCnt_q   <= '0;
      end else begin
         owner_q      <= owner_d;
         last_q       <= last_d;
         ownerValid_q <= ownerValid_d;
         burstCnt_q   <= burstCnt_d;
      end
   end

   // Non-granted channels and an idle downstream bus both see all-zero payloads.
   always_comb begin
      dn_read        = 1'b0;
      dn_write       = 1'b0;
      dn_address     = '0;
      dn_byte_enable = '0;
      dn_data_ctp    = '0;
      up_data_ptc    = '0;
      up_hit         = '0;
      up_inhibit     = '0;
      up_intercept   = '0;
      for (int i = 0; i < ChannelCount; i++) begin
         if (grant[i]) begin
            dn_read         = up_read[i];
            dn_write        = up_write[i];
            dn_address      = up_address[i];
            dn_byte_enable  = up_byte_enable[i];
            dn_data_ctp     = up_data_ctp[i];
            up_data_ptc[i]  = dn_data_ptc;
            up_hit[i]       = dn_hit;
            up_inhibit[i]   = dn_inhibit;
            up_intercept[i] = dn_intercept;
         end
      end
      up_grant = grant;
      up_stall = request & ~grant;
   end

endmodule

// File: tb/tb_arilla_bus_arbiter.sv
// Bench for arilla_bus_arbiter: a 3-channel burst-limited instance and a 3-channel unlimited
// instance share stimulus and are compared against a behavioural ownership model.
module tb_arilla_bus_arbiter;

   localparam int BW = 179;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic             rst;
   logic [2:0]       upRead, upWrite;
   logic [2:0][29:0] upAddress;
   logic [2:0][3:0]  upByteEnable;
   logic [2:0][31:0] upDataCtp;
   logic [31:0]      dnDataPtc;
   logic             dnHit, dnInhibit, dnIntercept;

   logic [2:0][31:0] aDataPtc, bDataPtc;
   logic [2:0]       aHit, aInhibit, aIntercept, aStall, aGrant;
   logic [2:0]       bHit, bInhibit, bIntercept, bStall, bGrant;
   logic             aDnRead, aDnWrite, bDnRead, bDnWrite;
   logic [29:0]      aDnAddress, bDnAddress;
   logic [3:0]       aDnByteEnable, bDnByteEnable;
   logic [31:0]      aDnDataCtp, bDnDataCtp;

   logic [BW-1:0] aAll, bAll;
   assign aAll = {aDataPtc, aHit, aInhibit, aIntercept, aStall, aGrant,
                  aDnRead, aDnWrite, aDnAddress, aDnByteEnable, aDnDataCtp};
   assign bAll = {bDataPtc, bHit, bInhibit, bIntercept, bStall, bGrant,
                  bDnRead, bDnWrite, bDnAddress, bDnByteEnable, bDnDataCtp};

   arilla_bus_arbiter #(.ChannelCount(3), .MaxBurst(2)) dutA (
      .clk(clk), .rst(rst),
      .up_read(upRead), .up_write(upWrite), .up_address(upAddress),
      .up_byte_enable(upByteEnable), .up_data_ctp(upDataCtp),
      .up_data_ptc(aDataPtc), .up_hit(aHit), .up_inhibit(aInhibit),
      .up_intercept(aIntercept), .up_stall(aStall), .up_grant(aGrant),
      .dn_read(aDnRead), .dn_write(aDnWrite), .dn_address(aDnAddress),
      .dn_byte_enable(aDnByteEnable), .dn_data_ctp(aDnDataCtp),
      .dn_data_ptc(dnDataPtc), .dn_hit(dnHit), .dn_inhibit(dnInhibit),
      .dn_intercept(dnIntercept)
   );

   arilla_bus_arbiter #(.ChannelCount(3), .MaxBurst(0)) dutB (
      .clk(clk), .rst(rst),
      .up_read(upRead), .up_write(upWrite), .up_address(upAddress),
      .up_byte_enable(upByteEnable), .up_data_ctp(upDataCtp),
      .up_data_ptc(bDataPtc), .up_hit(bHit), .up_inhibit(bInhibit),
      .up_intercept(bIntercept), .up_stall(bStall), .up_grant(bGrant),
      .dn_read(bDnRead), .dn_write(bDnWrite), .dn_address(bDnAddress),
      .dn_byte_enable(bDnByteEnable), .dn_data_ctp(bDnDataCtp),
      .dn_data_ptc(dnDataPtc), .dn_hit(dnHit), .dn_inhibit(dnInhibit),
      .dn_intercept(dnIntercept)
   );

   int ownerM[2];
   int runM[2];
   int lastM[2];
   int expIdx[2];
   logic [BW-1:0] expAll[2];
   int checks = 0;
   int errors = 0;

   // Model k=0 has a burst limit of 2, k=1 is unlimited; -1 means nobody holds the bus.
   function automatic int pickModel(int k);
      int         mb;
      int         own;
      bit         others;
      logic [2:0] req;
      mb     = (k == 0) ? 2 : 0;
      own    = ownerM[k];
      req    = upRead | upWrite;
      others = 1'b0;
      if (rst) return -1;
      if (own >= 0 && req[own]) begin
         for (int c = 0; c < 3; c++) if (c != own && req[c]) others = 1'b1;
         if (mb == 0 || runM[k] < mb || !others) return own;
      end
      for (int off = 1; off <= 3; off++) begin
         if (req[(lastM[k] + off) % 3]) return (lastM[k] + off) % 3;
      end
      return -1;
   endfunction

   function automatic logic [BW-1:0] bundleModel(int g);
      logic [2:0][31:0] dp;
      logic [2:0]       hit, inh, icp, gr;
      logic             rd, wr;
      logic [29:0]      ad;
      logic [3:0]       be;
      logic [31:0]      dd;
      dp = '0; hit = '0; inh = '0; icp = '0; gr = '0;
      rd = 1'b0; wr = 1'b0; ad = '0; be = '0; dd = '0;
      if (g >= 0) begin
         gr[g]  = 1'b1;
         dp[g]  = dnDataPtc;
         hit[g] = dnHit;
         inh[g] = dnInhibit;
         icp[g] = dnIntercept;
         rd = upRead[g]; wr = upWrite[g]; ad = upAddress[g];
         be = upByteEnable[g]; dd = upDataCtp[g];
      end
      return {dp, hit, inh, icp, (upRead | upWrite) & ~gr, gr, rd, wr, ad, be, dd};
   endfunction

   function automatic void commitModel(int k);
      int mb;
      int g;
      mb = (k == 0) ? 2 : 0;
      g  = expIdx[k];
      if (rst) begin
         ownerM[k] = -1; runM[k] = 0; lastM[k] = 2;
      end else if (g < 0) begin
         ownerM[k] = -1; runM[k] = 0;
      end else begin
         if (g == ownerM[k]) runM[k] = (mb > 0 && runM[k] >= mb) ? mb : runM[k] + 1;
         else runM[k] = 1;
         ownerM[k] = g;
         lastM[k]  = g;
      end
   endfunction

   task automatic setInputs(input logic r, input logic [2:0] rd, input logic [2:0] wr);
      rst     = r;
      upRead  = rd;
      upWrite = wr;
      for (int c = 0; c < 3; c++) begin
         upAddress[c]    = 30'($urandom);
         upByteEnable[c] = 4'($urandom);
         upDataCtp[c]    = $urandom;
      end
      dnDataPtc   = $urandom;
      dnHit       = 1'($urandom);
      dnInhibit   = 1'($urandom);
      dnIntercept = 1'($urandom);
   endtask

   task automatic settle();
      #2;
      for (int k = 0; k < 2; k++) begin
         expIdx[k] = pickModel(k);
         expAll[k] = bundleModel(expIdx[k]);
      end
   endtask

   task automatic stepClock();
      @(posedge clk);
      for (int k = 0; k < 2; k++) commitModel(k);
      #1;
   endtask

   task automatic applyReset();
      setInputs(1'b1, 3'b000, 3'b000);
      settle();
      stepClock();
   endtask

   task automatic test_reset();
      setInputs(1'b1, 3'b101, 3'b010);
      settle();
      checks++;
      if (aGrant !== 3'b000 || bGrant !== 3'b000) begin
         errors++;
         $display("[TB] FAIL reset_grant: got %b/%b expected 000", aGrant, bGrant);
      end
      checks++;
      if (aStall !== 3'b111 || aDnRead !== 1'b0 || aDnWrite !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_stall: got stall %b rd %b wr %b expected 111 0 0", aStall, aDnRead, aDnWrite);
      end
      checks++;
      if (aAll !== expAll[0] || bAll !== expAll[1]) begin
         errors++;
         $display("[TB] FAIL reset_bundle: got %h expected %h", aAll, expAll[0]);
      end
      stepClock();
   endtask

   task automatic test_single_read();
      applyReset();
      setInputs(1'b0, 3'b010, 3'b000);
      upAddress[1] = 30'h10;
      dnHit        = 1'b1;
      dnDataPtc    = 32'hDEADBEEF;
      settle();
      checks++;
      if (aGrant !== 3'b010 || aStall !== 3'b000) begin
         errors++;
         $display("[TB] FAIL single_grant: got grant %b stall %b expected 010 000", aGrant, aStall);
      end
      checks++;
      if (aDataPtc[1] !== 32'hDEADBEEF || aHit !== 3'b010) begin
         errors++;
         $display("[TB] FAIL single_resp: got data %h hit %b expected deadbeef 010", aDataPtc[1], aHit);
      end
      checks++;
      if (aDnAddress !== 30'h10 || aDnRead !== 1'b1 || aAll !== expAll[0]) begin
         errors++;
         $display("[TB] FAIL single_bundle: got %h expected %h", aAll, expAll[0]);
      end
      stepClock();
   endtask

   task automatic test_round_robin();
      int         seq[12] = '{0, 0, 1, 1, 2, 2, 0, 0, 1, 1, 2, 2};
      int         waitCnt[3] = '{0, 0, 0};
      int         maxWait = 0;
      logic [2:0] rd;
      applyReset();
      for (int cyc = 0; cyc < 12; cyc++) begin
         rd = 3'($urandom);
         setInputs(1'b0, rd, ~rd);
         settle();
         checks++;
         if (aGrant !== 3'(1 << seq[cyc]) || aAll !== expAll[0]) begin
            errors++;
            $display("[TB] FAIL rr_cycle%0d: got grant %b expected %b", cyc, aGrant, 3'(1 << seq[cyc]));
         end
         for (int c = 0; c < 3; c++) begin
            waitCnt[c] = aStall[c] ? waitCnt[c] + 1 : 0;
            if (waitCnt[c] > maxWait) maxWait = waitCnt[c];
         end
         stepClock();
      end
      checks++;
      if (maxWait > 4) begin
         errors++;
         $display("[TB] FAIL rr_stall_bound: got %0d expected <= 4", maxWait);
      end
   endtask

   task automatic test_burst_saturate();
      applyReset();
      for (int cyc = 0; cyc < 6; cyc++) begin
         setInputs(1'b0, 3'b001, 3'b000);
         settle();
         checks++;
         if (aGrant !== 3'b001 || bGrant !== 3'b001) begin
            errors++;
            $display("[TB] FAIL burst_alone%0d: got %b/%b expected 001", cyc, aGrant, bGrant);
         end
         stepClock();
      end
      setInputs(1'b0, 3'b011, 3'b000);
      settle();
      checks++;
      if (aGrant !== 3'b010 || bGrant !== 3'b001) begin
         errors++;
         $display("[TB] FAIL burst_saturated: got %b/%b expected 010/001", aGrant, bGrant);
      end
      stepClock();
   endtask

   task automatic test_back_to_back();
      applyReset();
      setInputs(1'b0, 3'b100, 3'b000);
      settle();
      checks++;
      if (aGrant !== 3'b100) begin
         errors++;
         $display("[TB] FAIL handover_owner: got %b expected 100", aGrant);
      end
      stepClock();
      setInputs(1'b0, 3'b000, 3'b001);
      settle();
      checks++;
      if (aGrant !== 3'b001 || aStall !== 3'b000 || aDnWrite !== 1'b1) begin
         errors++;
         $display("[TB] FAIL handover_wrap: got grant %b stall %b wr %b expected 001 000 1", aGrant, aStall, aDnWrite);
      end
      stepClock();
   endtask

   task automatic test_reset_mid_burst();
      applyReset();
      setInputs(1'b0, 3'b010, 3'b000);
      settle();
      stepClock();
      setInputs(1'b1, 3'b010, 3'b000);
      settle();
      checks++;
      if (aDnRead !== 1'b0 || aDnWrite !== 1'b0 || aStall !== 3'b010 || aGrant !== 3'b000) begin
         errors++;
         $display("[TB] FAIL midreset_cycle: got rd %b wr %b stall %b grant %b expected 0 0 010 000", aDnRead, aDnWrite, aStall, aGrant);
      end
      stepClock();
      setInputs(1'b0, 3'b011, 3'b000);
      settle();
      checks++;
      if (aGrant !== 3'b001) begin
         errors++;
         $display("[TB] FAIL midreset_restart: got %b expected 001", aGrant);
      end
      stepClock();
   endtask

   task automatic test_unlimited();
      applyReset();
      for (int cyc = 0; cyc < 10; cyc++) begin
         setInputs(1'b0, 3'b011, 3'b000);
         settle();
         checks++;
         if (bGrant !== 3'b001 || bStall !== 3'b010) begin
            errors++;
            $display("[TB] FAIL unlimited_hold%0d: got grant %b stall %b expected 001 010", cyc, bGrant, bStall);
         end
         stepClock();
      end
      setInputs(1'b0, 3'b010, 3'b000);
      settle();
      checks++;
      if (bGrant !== 3'b010) begin
         errors++;
         $display("[TB] FAIL unlimited_release: got %b expected 010", bGrant);
      end
      stepClock();
   endtask

   // Stalled channels hold their request, as a real controller would.
   task automatic test_random();
      logic [2:0] rd = 3'b000;
      logic [2:0] wr = 3'b000;
      logic       r;
      int         kind;
      applyReset();
      for (int cyc = 0; cyc < 300; cyc++) begin
         r = ($urandom_range(0, 49) == 0);
         for (int c = 0; c < 3; c++) begin
            if (!((rd[c] | wr[c]) && expIdx[0] != c && !rst)) begin
               kind  = $urandom_range(0, 3);
               rd[c] = (kind == 1 || kind == 3);
               wr[c] = (kind == 2);
            end
         end
         setInputs(r, rd, wr);
         settle();
         checks++;
         if (aAll !== expAll[0]) begin
            errors++;
            $display("[TB] FAIL random_a%0d: got %h expected %h", cyc, aAll, expAll[0]);
         end
         checks++;
         if (bAll !== expAll[1]) begin
            errors++;
            $display("[TB] FAIL random_b%0d: got %h expected %h", cyc, bAll, expAll[1]);
         end
         stepClock();
      end
   endtask

   initial begin
      for (int k = 0; k < 2; k++) begin
         ownerM[k] = -1; runM[k] = 0; lastM[k] = 2; expIdx[k] = -1;
      end
      test_reset();
      test_single_read();
      test_round_robin();
      test_burst_saturate();
      test_back_to_back();
      test_reset_mid_burst();
      test_unlimited();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/arilla_bus_arbiter.md
# arilla_bus_arbiter

Parametrised N-controller arbiter for the Arilla system bus. It places `ChannelCount` upstream controllers (hart fetch, hart load/store, debug module, DMA) onto one downstream Arilla bus. Arbitration is round-robin with zero-cycle grant and an optional burst limit, and response sidebands are routed back only to the granted channel. It sits between the controllers and the peripheral address decode.

## Interface
- `ChannelCount`, 2: number of upstream controllers, ≥1.
- `DataWidth`, 32: bus data width.
- `ByteAddressWidth`, 32: byte address width.
- `ByteSize`, 8: bits per byte lane.
- `MaxBurst`, 4: maximum consecutive cycles one owner holds the bus while others wait. 0 means unlimited.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `up_read`  in  [ChannelCount]  per-channel read request.
- `up_write`  in  [ChannelCount]  per-channel write request.
- `up_address`  in  [ChannelCount][WordAddressWidth]  word address.
- `up_byte_enable`  in  [ChannelCount][BytesPerWord]  byte lanes.
- `up_data_ctp`  in  [ChannelCount][DataWidth]  write data.
- `up_data_ptc`  out  [ChannelCount][DataWidth]  read data.
- `up_hit`  out  [ChannelCount]  hit response.
- `up_inhibit`  out  [ChannelCount]  inhibit sideband.
- `up_intercept`  out  [ChannelCount]  intercept sideband.
- `up_stall`  out  [ChannelCount]  request present but not granted this cycle.
- `up_grant`  out  [ChannelCount]  one-hot grant.
- `dn_read`, `dn_write`, `dn_address`, `dn_byte_enable`, `dn_data_ctp`  out  downstream Arilla bus, controller side.
- `dn_data_ptc`, `dn_hit`, `dn_inhibit`, `dn_intercept`  in  downstream Arilla bus, peripheral/debug side.

## Operation
- Channel `i` requests when `up_read[i] | up_write[i]`. Asserting both is illegal; they are forwarded unchanged.
- State registers:
  - `owner` index plus `owner_valid`.
  - `last`, the most recent owner, used for round-robin.
  - `burst_cnt`, width $clog2(MaxBurst+1).
- Keep decision: the current owner keeps the bus when it still requests AND (`MaxBurst`==0 OR `burst_cnt` < `MaxBurst` OR no other channel requests).
- Otherwise the grant goes to the first requesting channel scanning `last+1, last+2, …` modulo `ChannelCount`. Wrap-around from ChannelCount-1 to 0 is required.
- No requester means no grant: `dn_read`/`dn_write` are 0, the other `dn_*` outputs are 0, and `owner_valid` clears.
- Granted channel `g`:
  - Downstream gets `dn_* = up_*[g]`.
  - Channel `g` receives `up_data_ptc[g]`, `up_hit[g]`, `up_inhibit[g]` and `up_intercept[g]` from the downstream inputs.
  - All non-granted channels see 0 on these outputs.
- `up_stall[i] = request[i] & ~up_grant[i]`. A stalled controller holds its request stable.
- Burst counter:
  - On an ownership change, `burst_cnt` loads 1.
  - On keep, it saturates-increments to `MaxBurst`.
  - With no grant, it is 0.
- Simultaneous events: when the owner drops its request in the same cycle another channel raises one, the new channel is granted in that same cycle with no bubble.
- Reset:
  - `owner_valid`=0, `last`=ChannelCount-1 (channel 0 wins first), `burst_cnt`=0.
  - While `rst` is high, no grant is issued: `up_grant`=0, `dn_read`=`dn_write`=0, `up_stall`=request, and all response outputs are 0.
  - Reset mid-transfer drops ownership. After `rst` falls, arbitration restarts from channel 0.

## Timing
- Grant and all data/response paths are combinational from the request inputs and the registered state: zero cycles of arbitration latency.
- The downstream bus is single-cycle, so the read response is valid in the granted cycle.
- State updates at the rising edge of `clk` using the current cycle's grant.
- A channel that waits is granted within at most (ChannelCount-1)·MaxBurst+1 cycles when `MaxBurst`>0.
- `ChannelCount`=1: grant = request, with no stalls.

## Structure
- Package `arilla_bus_pkg`:
  - `BytesPerWord`/`WordAddressWidth` computation functions.
  - Request-kind enum (`IDLE`, `READ`, `WRITE`).
- Sub-module `arilla_rr_picker`: combinational round-robin one-hot picker.
  - Parameter: `Width`.
  - Inputs: `request`, `last`.
  - Outputs: `grant`, `grant_index`, `any`.
- The arbiter holds the state registers, the keep/burst logic and the data muxes.

## Test plan
- `ChannelCount`=3; ch1 reads addr 0x10, `dn_hit`=1, `dn_data_ptc`=0xDEADBEEF → `up_grant`=3'b010, `up_data_ptc[1]`=0xDEADBEEF, `up_hit[0]`=`up_hit[2]`=0, `up_stall`=0.
- After reset, all three channels request continuously with `MaxBurst`=2 → grant sequence 0,0,1,1,2,2,0,… and each stall is ≤4 cycles.
- `MaxBurst`=2; ch0 requests alone for 6 cycles → ch0 is granted every cycle and `burst_cnt` saturates at 2.
- ch2 owns the bus and drops its request in the same cycle ch0 raises one → ch0 is granted that cycle and wraps from last=2 with no idle cycle.
- `rst` is asserted for 1 cycle while ch1 owns the bus mid-burst → that cycle shows `dn_read`=`dn_write`=0 and `up_stall[1]`=1; next cycle with ch1 and ch0 requesting, ch0 is granted.
- `MaxBurst`=0; ch0 and ch1 both request for 10 cycles → ch0 holds all 10 cycles; ch1 is granted the cycle after ch0 releases.
